// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/halt sequencer that issues one-cycle CPU clock enables, debounces the panel
// buttons and owns the memory-browse address. Define BREAKPOINT_EN to add the PC breakpoint ports.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DIV0            = 2500000,
    parameter int unsigned DIV1            = 250000,
    parameter int unsigned DIV2            = 25000,
    parameter int unsigned DIV3            = 1,
    parameter int unsigned ADDR_W          = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_btn,
    input  logic              step_btn,
    input  logic              addr_btn,
    input  logic [1:0]        rate_sel,
    input  logic              browse_en,
    input  logic              cpu_halt,
`ifdef BREAKPOINT_EN
    input  logic              bp_valid,
    input  logic [31:0]       bp_pc,
    input  logic [31:0]       pc,
    output logic              bp_hit,
`endif
    output logic              cpu_ce,
    output logic              cpu_go,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       ce_count
);

    localparam int unsigned       DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ZERO  = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]   DB_ONE   = DB_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    logic [2:0]      raw_s;
    logic [2:0]      sync1_r;
    logic [2:0]      sync2_r;
    logic [2:0]      level_r;
    logic [2:0]      level_d_r;
    logic [2:0]      ev_r;
    logic [DB_W-1:0] db_cnt_r [3];
    logic            go_ev_s;
    logic            step_ev_s;
    logic            addr_ev_s;

    logic [1:0]      rate_r;
    logic [31:0]     tick_cnt_r;
    logic [31:0]     div_s;
    logic            rate_chg_s;
    logic            tick_s;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            ce_nxt_s;
    logic            go_nxt_s;
    logic            cpu_ce_r;
    logic            cpu_go_r;
    logic [31:0]     ce_count_r;
    logic [ADDR_W-1:0] mem_addr_r;

    assign raw_s     = {addr_btn, step_btn, go_btn};
    assign go_ev_s   = ev_r[0];
    assign step_ev_s = ev_r[1];
    assign addr_ev_s = ev_r[2];

    // Synchronize, debounce and edge-detect the three buttons; a level flips only after a full run of differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= 3'b000;
            sync2_r   <= 3'b000;
            level_r   <= 3'b000;
            level_d_r <= 3'b000;
            ev_r      <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= DB_ZERO;
            end
        end else begin
            sync1_r   <= raw_s;
            sync2_r   <= sync1_r;
            level_d_r <= level_r;
            ev_r      <= level_r & ~level_d_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == level_r[i]) begin
                    db_cnt_r[i] <= DB_ZERO;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    level_r[i]  <= sync2_r[i];
                    db_cnt_r[i] <= DB_ZERO;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
                end
            end
        end
    end

    // Rate divisor selection and tick decode; a rate change suppresses the tick for that cycle.
    always_comb begin
        div_s = DIV0;
        case (rate_sel)
            2'd0:    div_s = DIV0;
            2'd1:    div_s = DIV1;
            2'd2:    div_s = DIV2;
            2'd3:    div_s = DIV3;
            default: div_s = DIV0;
        endcase
        rate_chg_s = (rate_sel != rate_r);
        tick_s     = !rate_chg_s && (tick_cnt_r == (div_s - 32'd1));
    end

    // Tick counter; restarts from zero on a wrap or a rate change.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_r     <= rate_sel;
            tick_cnt_r <= 32'd0;
        end else begin
            rate_r <= rate_sel;
            if (rate_chg_s || tick_s) begin
                tick_cnt_r <= 32'd0;
            end else begin
                tick_cnt_r <= tick_cnt_r + 32'd1;
            end
        end
    end

`ifdef BREAKPOINT_EN
    logic bp_set_s;
    logic bp_hit_r;
    assign bp_hit = bp_hit_r;
`endif

    // Sequencer decisions; the enables decided here are registered below.
    always_comb begin
        state_nxt_s = state_r;
        ce_nxt_s    = 1'b0;
        go_nxt_s    = 1'b0;
`ifdef BREAKPOINT_EN
        bp_set_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (go_ev_s) begin
                    state_nxt_s = RUN;
                end else if (step_ev_s) begin
                    state_nxt_s = STEP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cpu_halt) begin
                    state_nxt_s = HALTED;
                end else if (go_ev_s) begin
                    state_nxt_s = IDLE;
`ifdef BREAKPOINT_EN
                end else if (tick_s && bp_valid && (pc == bp_pc)) begin
                    state_nxt_s = IDLE;
                    bp_set_s    = 1'b1;
`endif
                end else begin
                    ce_nxt_s = tick_s;
                end
            end
            STEP: begin
                if (cpu_halt) begin
                    state_nxt_s = HALTED;
                end else if (tick_s) begin
                    ce_nxt_s    = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STEP;
                end
            end
            HALTED: begin
                if (go_ev_s) begin
                    state_nxt_s = RUN;
                    go_nxt_s    = 1'b1;
                end else if (step_ev_s) begin
                    state_nxt_s = STEP;
                    go_nxt_s    = 1'b1;
                end else begin
                    state_nxt_s = HALTED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, enable pulses, saturating enable count and browse address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cpu_ce_r   <= 1'b0;
            cpu_go_r   <= 1'b0;
            ce_count_r <= 32'd0;
            mem_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            cpu_ce_r <= ce_nxt_s;
            cpu_go_r <= go_nxt_s;
            if (ce_nxt_s && (ce_count_r != 32'hFFFF_FFFF)) begin
                ce_count_r <= ce_count_r + 32'd1;
            end else begin
                ce_count_r <= ce_count_r;
            end
            if (!browse_en) begin
                mem_addr_r <= {ADDR_W{1'b0}};
            end else if (addr_ev_s) begin
                mem_addr_r <= mem_addr_r + ADDR_ONE;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
        end
    end

`ifdef BREAKPOINT_EN
    // Sticky breakpoint flag; a new hit outranks a coincident button event.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_hit_r <= 1'b0;
        end else if (bp_set_s) begin
            bp_hit_r <= 1'b1;
        end else if (go_ev_s || step_ev_s) begin
            bp_hit_r <= 1'b0;
        end else begin
            bp_hit_r <= bp_hit_r;
        end
    end
`endif

    assign state    = state_r;
    assign cpu_ce   = cpu_ce_r;
    assign cpu_go   = cpu_go_r;
    assign ce_count = ce_count_r;
    assign mem_addr = mem_addr_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a cycle model built from the behavioural rules plus
// directed scenarios with hand-computed expectations.
module tb_cpu_run_ctrl;

    localparam int DEB = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_HALT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go_btn = 1'b0, step_btn = 1'b0, addr_btn = 1'b0;
    logic [1:0]  rate_sel = 2'd1;
    logic        browse_en = 1'b0, cpu_halt = 1'b0;
    logic        cpu_ce, cpu_go;
    logic [1:0]  state;
    logic [9:0]  mem_addr;
    logic [31:0] ce_count;

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(DEB), .DIV0(8), .DIV1(4), .DIV2(2), .DIV3(1), .ADDR_W(10)
    ) dut (
        .clk(clk), .rst(rst), .go_btn(go_btn), .step_btn(step_btn), .addr_btn(addr_btn),
        .rate_sel(rate_sel), .browse_en(browse_en), .cpu_halt(cpu_halt),
        .cpu_ce(cpu_ce), .cpu_go(cpu_go), .state(state), .mem_addr(mem_addr), .ce_count(ce_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] hist [3];     // bit0 = newest raw sample
    int  m_lvl [3];
    int  m_rose [3];           // level rose on the latest edge
    int  m_ev [3];             // event visible to the sequencer this cycle
    int  m_phase, m_rate, m_state, m_addr;
    bit  m_ce, m_go;
    longint m_count;

    function automatic int mdiv(input logic [1:0] r);
        case (r)
            2'd0: return 8;
            2'd1: return 4;
            2'd2: return 2;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int raw [3];
        bit tick, ce_n, go_n, all_diff;
        int st_n;
        raw[0] = go_btn; raw[1] = step_btn; raw[2] = addr_btn;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                hist[i] = 16'h0000; m_lvl[i] = 0; m_rose[i] = 0; m_ev[i] = 0;
            end
            m_phase = 0; m_rate = rate_sel; m_state = S_IDLE; m_addr = 0;
            m_ce = 1'b0; m_go = 1'b0; m_count = 0;
        end else begin
            if (rate_sel != m_rate) begin
                tick = 1'b0; m_phase = 0;
            end else begin
                tick = (m_phase == mdiv(rate_sel) - 1);
                m_phase = (m_phase + 1) % mdiv(rate_sel);
            end
            m_rate = rate_sel;
            ce_n = 1'b0; go_n = 1'b0; st_n = m_state;
            case (m_state)
                S_IDLE: if (m_ev[0] != 0) st_n = S_RUN; else if (m_ev[1] != 0) st_n = S_STEP;
                S_RUN:  if (cpu_halt) st_n = S_HALT; else if (m_ev[0] != 0) st_n = S_IDLE; else ce_n = tick;
                S_STEP: if (cpu_halt) st_n = S_HALT; else if (tick) begin ce_n = 1'b1; st_n = S_IDLE; end
                default: if (m_ev[0] != 0) begin st_n = S_RUN; go_n = 1'b1; end
                         else if (m_ev[1] != 0) begin st_n = S_STEP; go_n = 1'b1; end
            endcase
            if (!browse_en) m_addr = 0;
            else if (m_ev[2] != 0) m_addr = (m_addr + 1) % 1024;
            if (ce_n && m_count < 64'hFFFF_FFFF) m_count++;
            m_state = st_n; m_ce = ce_n; m_go = go_n;
            // synchronized sample window: raw taken 2..DEB+1 edges ago
            for (int i = 0; i < 3; i++) begin
                m_ev[i] = m_rose[i];
                all_diff = 1'b1;
                for (int k = 1; k <= DEB; k++) if (int'(hist[i][k]) == m_lvl[i]) all_diff = 1'b0;
                m_rose[i] = 0;
                if (all_diff) begin
                    m_rose[i] = (m_lvl[i] == 0) ? 1 : 0;
                    m_lvl[i] = 1 - m_lvl[i];
                end
                hist[i] = {hist[i][14:0], raw[i][0]};
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", state, m_state);
            chk("cpu_ce", cpu_ce, m_ce);
            chk("cpu_go", cpu_go, m_go);
            chk("mem_addr", mem_addr, m_addr);
            chk("ce_count", ce_count, m_count);
            chk("ce_go_exclusive", cpu_ce & cpu_go, 0);
        end
    end

    // Event monitors for the directed checks.
    int ce_seen = 0, go_seen = 0, run_entries = 0;
    logic [1:0] last_state = 2'd0;
    always @(posedge clk) begin
        if (cpu_ce) ce_seen++;
        if (cpu_go) go_seen++;
        if (state == 2'd1 && last_state == 2'd0) run_entries++;
        last_state = state;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2); rst = 1'b0;
    endtask

    task automatic press(input int which, input int hold, input int rel);
        if (which == 0) go_btn = 1'b1; else if (which == 1) step_btn = 1'b1; else addr_btn = 1'b1;
        cyc(hold);
        go_btn = 1'b0; step_btn = 1'b0; addr_btn = 1'b0;
        cyc(rel);
    endtask

    initial begin : stim
        int c0, g0, pulses, last_idx, gap_bad;
        @(negedge clk);
        do_reset();
        chk_en = 1'b1;
        chk("reset_state", state, 0);
        chk("reset_ce", cpu_ce, 0);
        chk("reset_count", ce_count, 0);
        chk("reset_addr", mem_addr, 0);

        // 1: run at rate 1 -> one enable every 4 clocks
        press(0, 10, 0);
        chk("t1_state_run", state, 1);
        pulses = 0; last_idx = -1; gap_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_ce) begin
                if (last_idx >= 0 && i - last_idx != 4) gap_bad++;
                last_idx = i; pulses++;
            end
        end
        chk("t1_pulses_in_40", pulses, 10);
        chk("t1_gap_errors", gap_bad, 0);
        chk("t1_still_run", state, 1);

        // 2: three single steps from IDLE
        do_reset();
        c0 = ce_seen;
        for (int s = 0; s < 3; s++) begin
            press(1, 10, 10);
            chk("t2_back_idle", state, 0);
        end
        chk("t2_ce_pulses", ce_seen - c0, 3);
        chk("t2_ce_count", ce_count, 3);

        // 3: halt while running, then resume with go
        do_reset();
        press(0, 10, 8);
        cpu_halt = 1'b1;
        cyc(1);
        c0 = ce_seen;
        cyc(10);
        chk("t3_no_ce_halted", ce_seen - c0, 0);
        chk("t3_halted", state, 3);
        cpu_halt = 1'b0;
        g0 = go_seen;
        press(0, 10, 10);
        chk("t3_go_pulses", go_seen - g0, 1);
        chk("t3_run_again", state, 1);
        chk("t3_ce_resumed", (ce_seen - c0) > 0 ? 1 : 0, 1);

        // 4: bouncing go yields exactly one start
        do_reset();
        c0 = run_entries;
        for (int b = 0; b < 3; b++) begin
            go_btn = 1'b1; cyc(2); go_btn = 1'b0; cyc(2);
        end
        press(0, 10, 10);
        chk("t4_run_entries", run_entries - c0, 1);
        chk("t4_state_run", state, 1);

        // 5: browse address wraps after 1024 increments
        do_reset();
        browse_en = 1'b1;
        cyc(1);
        for (int a = 0; a < 1025; a++) press(2, 6, 6);
        chk("t5_addr_wrap", mem_addr, 1);
        browse_en = 1'b0;
        press(2, 10, 10);
        chk("t5_addr_cleared", mem_addr, 0);

        // 6: rate change mid-count, then reset mid-run
        do_reset();
        rate_sel = 2'd0;
        cyc(2);
        press(0, 10, 3);
        chk("t6_run", state, 1);
        rate_sel = 2'd3;
        cyc(1);
        chk("t6_no_tick_on_change", cpu_ce, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk("t6_ce_every_clk", cpu_ce, 1);
        end
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_ce", cpu_ce, 0);
        chk("t6_rst_state", state, 0);
        rst = 1'b0;
        cyc(5);
        chk("t6_idle_after_rst", state, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/halt sequencer for the single-cycle CPU on the board top level. It replaces free-running divided CPU clocks with one-cycle clock-enable pulses (cpu_ce) on the board clock, at a selectable rate. It debounces the go, step and address-browse buttons, and owns the memory-browse address counter fed to the CPU debug port.

Parameters:
DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples needed to accept a button level change
DIV0, 2500000, rate_sel=0 tick divisor (slowest)
DIV1, 250000, rate_sel=1 tick divisor
DIV2, 25000, rate_sel=2 tick divisor
DIV3, 1, rate_sel=3 tick divisor (tick every clk)
ADDR_W, 10, width of browse address

Ports:
clk  in  1  board clock; single clock domain
rst  in  1  synchronous, active-high reset
go_btn  in  1  raw button: start/pause/resume
step_btn  in  1  raw button: single instruction step
addr_btn  in  1  raw button: increment browse address
rate_sel  in  2  selects DIV0..DIV3
browse_en  in  1  memory-browse mode enable (dataSel[2])
cpu_halt  in  1  CPU halt flag
cpu_ce  out  1  one-cycle CPU clock enable
cpu_go  out  1  one-cycle resume pulse to CPU after halt
state  out  2  0=IDLE 1=RUN 2=STEP 3=HALTED
mem_addr  out  ADDR_W  browse address
ce_count  out  32  number of cpu_ce pulses issued, saturating

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; cpu_ce=0; cpu_go=0; mem_addr=0; ce_count=0; debounce and tick counters=0; debounced levels=0. Reset mid-RUN or mid-STEP aborts immediately, with no further cpu_ce.
- Buttons: each passes through a 2-flop synchronizer and then a debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive differing samples; the counter clears on any matching sample. A rising edge of the debounced level gives a 1-cycle event (go_ev, step_ev, addr_ev). Latency from a stable raw press to its event is 2+DEBOUNCE_CYCLES+1 clks. Holding a button produces exactly one event.
- Tick: tick_cnt counts 0..DIV-1; tick=1 when tick_cnt==DIV-1, then the counter wraps to 0. A rate_sel change, sampled against a registered copy, clears tick_cnt with no tick that cycle. DIV=1 gives tick every cycle.
- FSM, evaluated in priority order per cycle:
  - IDLE: go_ev->RUN; else step_ev->STEP. cpu_ce=0.
  - RUN: cpu_halt=1->HALTED, cpu_ce=0 that cycle. Else go_ev->IDLE (pause), no ce that cycle. Else cpu_ce=tick.
  - STEP: wait for tick, then cpu_ce=1 for that cycle and ->IDLE. cpu_halt=1 while waiting->HALTED with no ce. go_ev and step_ev are ignored in STEP.
  - HALTED: go_ev->RUN and cpu_go=1 for that one cycle. step_ev->STEP and cpu_go=1. cpu_ce=0 in HALTED.
- cpu_ce and cpu_go are registered outputs: asserted the cycle after the decision. cpu_go and cpu_ce are never both 1 in the same cycle.
- ce_count: +1 per cpu_ce; holds at 32'hFFFF_FFFF.
- mem_addr: browse_en=0 clears it to 0 every cycle. browse_en=1 and addr_ev give +1 with wrap at 2^ADDR_W-1->0. browse_en=0 and addr_ev in the same cycle: the clear wins.

Optional Feature:
BREAKPOINT_EN. When defined, the block adds inputs bp_valid(1), bp_pc(32) and pc(32), plus output bp_hit(1).
- In RUN: if bp_valid=1 and pc==bp_pc on a tick cycle, the ce is suppressed, state goes to IDLE, and bp_hit sets.
- bp_hit is sticky. It clears on the next go_ev or step_ev, or on rst.
- STEP ignores the breakpoint, so stepping off the breakpoint works.
When the macro is undefined, these ports do not exist and RUN behaves as above.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, DIV0=8, DIV1=4, DIV2=2, DIV3=1.
1. Reset, rate_sel=1, press go for 10 clks, wait 40 clks -> state=RUN; cpu_ce pulses exactly every 4 clks; ce_count increments per pulse.
2. In IDLE, press step 3 times, releasing for 10 clks each -> exactly 3 cpu_ce pulses; ce_count=3; state returns to IDLE after each.
3. RUN, raise cpu_halt -> no cpu_ce from the cycle halt is seen; state=HALTED. Drop halt, press go -> cpu_go single pulse, state=RUN, ce resumes.
4. Bounce go_btn at 1-0-1-0 every 2 clks for 12 clks, then hold high -> exactly one go_ev, giving a single IDLE->RUN transition.
5. browse_en=1, press addr 1025 times -> mem_addr=1 (wrap). Drop browse_en while pressing addr -> mem_addr=0.
6. RUN at rate_sel=0, switch to 3 mid-count -> no tick on the change cycle, then cpu_ce every clk. Assert rst mid-RUN -> cpu_ce=0 next cycle and state=IDLE.
